// File: rtl/filter_pair_gather.sv
// Snapshots the 6x6 filter matrix on load and streams surviving (filterBit & ~drop)
// entries one per cycle over valid/ready, in ascending entry order.
module filter_pair_gather #(
  parameter int N_ENT = 36,
  parameter int OUT_W = 6,
  parameter int WGT_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [N_ENT-1:0]       filterBit,
  input  logic [N_ENT-1:0]       drop,
  input  logic [N_ENT*OUT_W-1:0] filterOut,
  input  logic [N_ENT*WGT_W-1:0] filterWeight,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_idx,
  output logic [2:0]             out_row,
  output logic [2:0]             out_col,
  output logic [OUT_W-1:0]       out_pair,
  output logic [WGT_W-1:0]       out_weight,
  output logic                   out_last,
  output logic [5:0]             pair_count,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [N_ENT-1:0]       mask;
  logic [N_ENT*OUT_W-1:0] out_buf;
  logic [N_ENT*WGT_W-1:0] wgt_buf;

  logic [N_ENT-1:0]       cand;
  logic [5:0]             cand_cnt;
  logic [N_ENT-1:0]       live;
  logic [N_ENT-1:0]       onehot;
  logic                   found;

  always_comb begin
    cand     = filterBit & ~drop;
    cand_cnt = '0;
    for (int unsigned i = 0; i < N_ENT; i++)
      cand_cnt = cand_cnt + 6'(cand[i]);
  end

  // Lowest-set-bit select; row/col are per-iteration constants, so no divider is built.
  always_comb begin
    live       = (state == RUN) ? mask : '0;
    onehot     = '0;
    found      = 1'b0;
    out_idx    = '0;
    out_row    = '0;
    out_col    = '0;
    out_pair   = '0;
    out_weight = '0;
    for (int unsigned i = 0; i < N_ENT; i++) begin
      if (live[i] && !found) begin
        found      = 1'b1;
        onehot[i]  = 1'b1;
        out_idx    = 6'(i);
        out_row    = 3'(i / 6);
        out_col    = 3'(i % 6);
        out_pair   = out_buf[i*OUT_W +: OUT_W];
        out_weight = wgt_buf[i*WGT_W +: WGT_W];
      end
    end
  end

  assign out_valid = found;
  assign out_last  = found && ((live & (live - 1'b1)) == '0);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mask       <= '0;
      out_buf    <= '0;
      wgt_buf    <= '0;
      pair_count <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          out_buf    <= filterOut;
          wgt_buf    <= filterWeight;
          mask       <= cand;
          pair_count <= cand_cnt;
          state      <= RUN;
        end
        RUN: begin
          if (mask == '0)
            state <= DONE;
          else if (out_valid && out_ready)
            mask <= mask & ~onehot;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
